// File: rtl/proc_io_bridge.sv
// Buffered I/O bridge between the processor's address-decoded I/O port and
// per-channel external sample streams, with one FIFO per channel and a processor stall.
module proc_io_bridge #(
  parameter int NBDATA = 28,
  parameter int NCHIN  = 4,
  parameter int NCHOUT = 4,
  parameter int NBAIN  = 2,
  parameter int NBAOUT = 2,
  parameter int FDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCHIN*NBDATA-1:0]  ext_in_data,
  input  logic [NCHIN-1:0]         ext_in_valid,
  output logic [NCHIN-1:0]         ext_in_ready,
  output logic [NCHOUT*NBDATA-1:0] ext_out_data,
  output logic [NCHOUT-1:0]        ext_out_valid,
  input  logic [NCHOUT-1:0]        ext_out_ready,
  input  logic                     proc_req_in,
  input  logic [NBAIN-1:0]         addr_in,
  output logic [NBDATA-1:0]        proc_in_data,
  input  logic                     proc_out_en,
  input  logic [NBAOUT-1:0]        addr_out,
  input  logic [NBDATA-1:0]        proc_out_data,
  output logic                     proc_stall,
  output logic                     err_addr
);
  localparam int PW = $clog2(FDEPTH);
  localparam int CW = PW + 1;

  // Handshake: a word moves on a rising edge where valid and ready are both high;
  // ready never depends on valid, and the processor side is blocked via proc_stall.
  logic [31:0]       ain_i, aout_i;
  logic [NCHIN-1:0]  in_empty;
  logic [NBDATA-1:0] in_head [NCHIN];
  logic [NCHOUT-1:0] out_full;
  logic              in_rng, out_rng, rd_empty, wr_full;
  logic [NBDATA-1:0] rd_data;
  logic              err_addr_q, err_addr_d;

  assign ain_i  = 32'(addr_in);
  assign aout_i = 32'(addr_out);

  for (genvar k = 0; k < NCHIN; k++) begin : g_in
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [NBDATA-1:0] mem_q [FDEPTH];
    logic [NBDATA-1:0] mem_d [FDEPTH];
    logic              push, pop, full;

    // Ready comes from count alone, so a full FIFO refuses a push even during a pop.
    assign full            = (cnt_q == CW'(FDEPTH));
    assign in_empty[k]     = (cnt_q == '0);
    assign ext_in_ready[k] = ~full & rst;
    assign push            = ext_in_valid[k] & ext_in_ready[k];
    assign pop             = proc_req_in & (ain_i == 32'(k)) & ~in_empty[k];
    assign in_head[k]      = mem_q[rp_q];

    always_comb begin
      cnt_d = cnt_q;
      wp_d  = wp_q;
      rp_d  = rp_q;
      mem_d = mem_q;
      if (push) begin
        mem_d[wp_q] = ext_in_data[k*NBDATA +: NBDATA];
        wp_d        = wp_q + PW'(1);
      end
      if (pop) rp_d = rp_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
        wp_q  <= '0;
        rp_q  <= '0;
      end else begin
        cnt_q <= cnt_d;
        wp_q  <= wp_d;
        rp_q  <= rp_d;
      end
    end

    always_ff @(posedge clk) mem_q <= mem_d;
  end

  for (genvar k = 0; k < NCHOUT; k++) begin : g_out
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [NBDATA-1:0] mem_q [FDEPTH];
    logic [NBDATA-1:0] mem_d [FDEPTH];
    logic              push, pop;

    assign out_full[k]                        = (cnt_q == CW'(FDEPTH));
    assign ext_out_valid[k]                   = (cnt_q != '0);
    assign ext_out_data[k*NBDATA +: NBDATA]   = mem_q[rp_q];
    assign push = proc_out_en & (aout_i == 32'(k)) & ~out_full[k];
    assign pop  = ext_out_valid[k] & ext_out_ready[k];

    always_comb begin
      cnt_d = cnt_q;
      wp_d  = wp_q;
      rp_d  = rp_q;
      mem_d = mem_q;
      if (push) begin
        mem_d[wp_q] = proc_out_data;
        wp_d        = wp_q + PW'(1);
      end
      if (pop) rp_d = rp_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
        wp_q  <= '0;
        rp_q  <= '0;
      end else begin
        cnt_q <= cnt_d;
        wp_q  <= wp_d;
        rp_q  <= rp_d;
      end
    end

    always_ff @(posedge clk) mem_q <= mem_d;
  end

  // Decode the selected channels; an unmatched address leaves the defaults.
  always_comb begin
    rd_empty = 1'b1;
    rd_data  = '0;
    wr_full  = 1'b0;
    for (int i = 0; i < NCHIN; i++) begin
      if (ain_i == 32'(i)) begin
        rd_empty = in_empty[i];
        rd_data  = in_head[i];
      end
    end
    for (int i = 0; i < NCHOUT; i++) begin
      if (aout_i == 32'(i)) wr_full = out_full[i];
    end
  end

  assign in_rng       = (ain_i < 32'(NCHIN));
  assign out_rng      = (aout_i < 32'(NCHOUT));
  assign proc_in_data = (in_rng && !rd_empty) ? rd_data : '0;
  assign proc_stall   = rst & ((proc_req_in & in_rng & rd_empty) |
                               (proc_out_en & out_rng & wr_full));
  assign err_addr_d   = err_addr_q | (proc_req_in & ~in_rng) | (proc_out_en & ~out_rng);
  assign err_addr     = err_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_addr_q <= 1'b0;
    else      err_addr_q <= err_addr_d;
  end
endmodule
